// File: rtl/cte_pkg.sv
// Shared types, colour-space coefficients and the round/saturate helper for cte_stream.
package cte_pkg;

    typedef enum logic {
        MODE_YUV2RGB = 1'b0,
        MODE_RGB2YUV = 1'b1
    } cte_mode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_Y0,
        S_V,
        S_CALC0,
        S_Y1,
        S_CALC1,
        S_EMIT_U,
        S_EMIT_Y0,
        S_EMIT_V,
        S_P1,
        S_EMIT_Y1
    } cte_state_e;

    // RGB->YUV coefficients, Q15
    localparam int C_Y_R = 9533;
    localparam int C_Y_G = 20654;
    localparam int C_Y_B = 2582;
    localparam int C_U_R = 4766;
    localparam int C_U_G = 10327;
    localparam int C_U_B = 15093;
    localparam int C_V_R = 14299;
    localparam int C_V_G = 12710;
    localparam int C_V_B = 1589;
    localparam int CSC_SHIFT = 15;

    // YUV->RGB coefficients in eighths: 1.625, 0.25, 0.75, 2
    localparam int C_RV_Q3 = 13;
    localparam int C_GU_Q3 = 2;
    localparam int C_GV_Q3 = 6;
    localparam int C_BU_Q3 = 16;

    function automatic int fx_coef(input int eighths, input int frac);
        return (eighths << frac) >> 3;
    endfunction

    // Round half-up at bit 'sh', then clamp to [lo, hi].
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] x,
                                                     input int sh,
                                                     input logic signed [63:0] lo,
                                                     input logic signed [63:0] hi);
        logic signed [63:0] r;
        r = (x + (64'sd1 <<< (sh - 1))) >>> sh;
        if (r < lo)
            r = lo;
        else if (r > hi)
            r = hi;
        return r;
    endfunction

endpackage

// File: rtl/cte_ofifo.sv
// Output FIFO for cte_stream; push and pop may coincide when full.
module cte_ofifo
    import cte_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk_p,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_en;
    logic             pop_en;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_en)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_p) begin
        if (push_en)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cte_stream.sv
// Streaming YUV 4:2:2 <-> RGB colour transform with output FIFO.
// Optional group counter output grp_cnt when CTE_GROUP_CNT_EN is defined.
module cte_stream
    import cte_pkg::*;
#(
    parameter int DW          = 8,
    parameter int FRAC        = 3,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic            clk_p,
    input  logic            reset_n,
    input  logic            op_mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3*DW-1:0] out_data,
    output logic            out_mode,
    output logic            idle
`ifdef CTE_GROUP_CNT_EN
    ,
    output logic [15:0]     grp_cnt
`endif
);

    localparam int CW = DW + 4 + FRAC;
    localparam int PW = 2 * DW + 16;
    localparam int FW = 3 * DW + 1;

    localparam logic signed [CW-1:0] K_RV = CW'(fx_coef(C_RV_Q3, FRAC));
    localparam logic signed [CW-1:0] K_GU = CW'(fx_coef(C_GU_Q3, FRAC));
    localparam logic signed [CW-1:0] K_GV = CW'(fx_coef(C_GV_Q3, FRAC));
    localparam logic signed [CW-1:0] K_BU = CW'(fx_coef(C_BU_Q3, FRAC));

    localparam logic signed [PW-1:0] K_YR = PW'(C_Y_R);
    localparam logic signed [PW-1:0] K_YG = PW'(C_Y_G);
    localparam logic signed [PW-1:0] K_YB = PW'(C_Y_B);
    localparam logic signed [PW-1:0] K_UR = PW'(C_U_R);
    localparam logic signed [PW-1:0] K_UG = PW'(C_U_G);
    localparam logic signed [PW-1:0] K_UB = PW'(C_U_B);
    localparam logic signed [PW-1:0] K_VR = PW'(C_V_R);
    localparam logic signed [PW-1:0] K_VG = PW'(C_V_G);
    localparam logic signed [PW-1:0] K_VB = PW'(C_V_B);

    localparam logic signed [63:0] PIX_MIN = 64'sd0;
    localparam logic signed [63:0] PIX_MAX = 64'((1 << DW) - 1);
    localparam logic signed [63:0] CHR_MIN = 64'(-(1 << (DW - 1)));
    localparam logic signed [63:0] CHR_MAX = 64'((1 << (DW - 1)) - 1);

    cte_state_e      state;
    cte_state_e      state_nxt;
    cte_mode_e       mode_r;
    logic [DW-1:0]   u_r;
    logic [DW-1:0]   v_r;
    logic [DW-1:0]   y_r;
    logic [3*DW-1:0] p_r;

    logic            accept_st;
    logic            acc;
    logic            push;
    logic            pop;
    logic            can_push;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FW-1:0]   push_data;
    logic [FW-1:0]   fifo_rd;

    logic signed [CW-1:0] y_s, u_s, v_s;
    logic signed [CW-1:0] r_acc, g_acc, b_acc;
    logic signed [PW-1:0] rr_s, gg_s, bb_s;
    logic signed [PW-1:0] yy_acc, uu_acc, vv_acc;
    logic [3*DW-1:0]      rgb_res;
    logic [DW-1:0]        y_res, u_res, v_res;

    // A full FIFO can still take a push in the cycle it is being popped.
    assign pop       = !fifo_empty && out_ready;
    assign can_push  = !fifo_full || out_ready;
    assign accept_st = (state == S_IDLE) || (state == S_Y0) || (state == S_V) ||
                       (state == S_Y1) || (state == S_P1);
    assign in_ready  = accept_st && can_push;
    assign acc       = in_valid && in_ready;

    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            mode_r <= MODE_YUV2RGB;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && acc)
                mode_r <= cte_mode_e'(op_mode);
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            S_IDLE:    if (acc) state_nxt = (cte_mode_e'(op_mode) == MODE_RGB2YUV) ? S_EMIT_U : S_Y0;
            S_Y0:      if (acc) state_nxt = S_V;
            S_V:       if (acc) state_nxt = S_CALC0;
            S_CALC0:   if (can_push) begin push = 1'b1; state_nxt = S_Y1; end
            S_Y1:      if (acc) state_nxt = S_CALC1;
            S_CALC1:   if (can_push) begin push = 1'b1; state_nxt = S_IDLE; end
            S_EMIT_U:  if (can_push) begin push = 1'b1; state_nxt = S_EMIT_Y0; end
            S_EMIT_Y0: if (can_push) begin push = 1'b1; state_nxt = S_EMIT_V; end
            S_EMIT_V:  if (can_push) begin push = 1'b1; state_nxt = S_P1; end
            S_P1:      if (acc) state_nxt = S_EMIT_Y1;
            S_EMIT_Y1: if (can_push) begin push = 1'b1; state_nxt = S_IDLE; end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Operand registers: the compute stage works only from these.
    always_ff @(posedge clk_p) begin
        if (acc) begin
            case (state)
                S_IDLE:     begin u_r <= in_data[DW-1:0]; p_r <= in_data; end
                S_Y0, S_Y1: y_r <= in_data[DW-1:0];
                S_V:        v_r <= in_data[DW-1:0];
                S_P1:       p_r <= in_data;
                default:    ;
            endcase
        end
    end

    always_comb begin
        y_s   = $signed({{(CW - DW){1'b0}}, y_r});
        u_s   = $signed({{(CW - DW){u_r[DW-1]}}, u_r});
        v_s   = $signed({{(CW - DW){v_r[DW-1]}}, v_r});
        r_acc = (y_s <<< FRAC) + K_RV * v_s;
        g_acc = (y_s <<< FRAC) - K_GU * u_s - K_GV * v_s;
        b_acc = (y_s <<< FRAC) + K_BU * u_s;
        rgb_res = {DW'(round_sat(64'(r_acc), FRAC, PIX_MIN, PIX_MAX)),
                   DW'(round_sat(64'(g_acc), FRAC, PIX_MIN, PIX_MAX)),
                   DW'(round_sat(64'(b_acc), FRAC, PIX_MIN, PIX_MAX))};

        rr_s   = $signed({{(PW - DW){1'b0}}, p_r[3*DW-1:2*DW]});
        gg_s   = $signed({{(PW - DW){1'b0}}, p_r[2*DW-1:DW]});
        bb_s   = $signed({{(PW - DW){1'b0}}, p_r[DW-1:0]});
        yy_acc = K_YR * rr_s + K_YG * gg_s + K_YB * bb_s;
        uu_acc = K_UB * bb_s - K_UR * rr_s - K_UG * gg_s;
        vv_acc = K_VR * rr_s - K_VG * gg_s - K_VB * bb_s;
        y_res  = DW'(round_sat(64'(yy_acc), CSC_SHIFT, PIX_MIN, PIX_MAX));
        u_res  = DW'(round_sat(64'(uu_acc), CSC_SHIFT, CHR_MIN, CHR_MAX));
        v_res  = DW'(round_sat(64'(vv_acc), CSC_SHIFT, CHR_MIN, CHR_MAX));
    end

    always_comb begin
        push_data = {mode_r, rgb_res};
        case (state)
            S_EMIT_U:             push_data = {mode_r, {(2 * DW){1'b0}}, u_res};
            S_EMIT_Y0, S_EMIT_Y1: push_data = {mode_r, {(2 * DW){1'b0}}, y_res};
            S_EMIT_V:             push_data = {mode_r, {(2 * DW){1'b0}}, v_res};
            default:              ;
        endcase
    end

    cte_ofifo #(
        .WIDTH (FW),
        .DEPTH (OFIFO_DEPTH)
    ) u_ofifo (
        .clk_p     (clk_p),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_rd[3*DW-1:0] : '0;
    assign out_mode  = out_valid && fifo_rd[3*DW];
    assign idle      = (state == S_IDLE) && fifo_empty;

`ifdef CTE_GROUP_CNT_EN
    logic grp_done;
    assign grp_done = push && ((state == S_CALC1) || (state == S_EMIT_Y1));

    always_ff @(posedge clk_p or negedge reset_n) begin
        if (!reset_n)
            grp_cnt <= '0;
        else if (grp_done)
            grp_cnt <= grp_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_cte_stream.sv
// Directed bench for cte_stream: both conversion directions, back-pressure, mode switching, reset.
module tb_cte_stream;

    logic        clk_p = 1'b0;
    logic        reset_n;
    logic        op_mode;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_mode;
    logic        idle;
`ifdef CTE_GROUP_CNT_EN
    logic [15:0] grp_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [24:0] got_q[$];
    logic [24:0] exp_q[$];

    always #5 clk_p = ~clk_p;

    cte_stream dut (
        .clk_p     (clk_p),
        .reset_n   (reset_n),
        .op_mode   (op_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .idle      (idle)
`ifdef CTE_GROUP_CNT_EN
        ,
        .grp_cnt   (grp_cnt)
`endif
    );

    // Record every beat that leaves the block.
    always @(negedge clk_p) begin
        if (reset_n && out_valid && out_ready)
            got_q.push_back({out_mode, out_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_p);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input logic m);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        op_mode  = m;
        while (in_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (n >= 40)
            chk("send_timeout", 32'(n), 32'd0);
        step();
        in_valid = 1'b0;
    endtask

    task automatic group_yuv(input logic [7:0] u, input logic [7:0] y0,
                             input logic [7:0] v, input logic [7:0] y1);
        send({16'h0, u}, 1'b0);
        send({16'h0, y0}, 1'b0);
        send({16'h0, v}, 1'b0);
        send({16'h0, y1}, 1'b0);
    endtask

    task automatic group_rgb(input logic [23:0] p0, input logic [23:0] p1);
        send(p0, 1'b1);
        send(p1, 1'b1);
    endtask

    task automatic expect_out(input logic m, input logic [23:0] d);
        exp_q.push_back({m, d});
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic compare_q(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset_n   = 1'b1;
        op_mode   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2 reset_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_mode", 32'(out_mode), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
`ifdef CTE_GROUP_CNT_EN
        chk("rst_grp_cnt", 32'(grp_cnt), 32'd0);
`endif
        step();
        reset_n = 1'b1;
        step();

        // 1: basic YUV->RGB and latency from the V beat
        send(24'h000000, 1'b0);
        chk("t1_busy", 32'(idle), 32'd0);
        send(24'h000080, 1'b0);
        send(24'h000000, 1'b0);
        chk("t1_lat_a", 32'(out_valid), 32'd0);
        step();
        chk("t1_lat_b", 32'(out_valid), 32'd1);
        chk("t1_first", 32'(out_data), 32'h808080);
        send(24'h000040, 1'b0);
        expect_out(1'b0, 24'h808080);
        expect_out(1'b0, 24'h404040);
        wait_idle("t1");
        compare_q("t1");

        // 2: rounding and saturation, including negative chroma
        group_yuv(8'h10, 8'h80, 8'h00, 8'hFF);
        group_yuv(8'h00, 8'hFF, 8'h7F, 8'h00);
        group_yuv(8'h80, 8'h80, 8'h80, 8'h10);
        expect_out(1'b0, 24'h807CA0);
        expect_out(1'b0, 24'hFFFBFF);
        expect_out(1'b0, 24'hFFA0FF);
        expect_out(1'b0, 24'hCE0000);
        expect_out(1'b0, 24'h00FF00);
        expect_out(1'b0, 24'h009000);
        wait_idle("t2");
        compare_q("t2");

        // 3: RGB->YUV
        group_rgb(24'hFFFFFF, 24'hFFFFFF);
        group_rgb(24'h000000, 24'h000000);
        group_rgb(24'hFF0000, 24'h0000FF);
        expect_out(1'b1, 24'h000000);
        expect_out(1'b1, 24'h0000FF);
        expect_out(1'b1, 24'h000000);
        expect_out(1'b1, 24'h0000FF);
        for (int i = 0; i < 4; i++) expect_out(1'b1, 24'h000000);
        expect_out(1'b1, 24'h0000DB);
        expect_out(1'b1, 24'h00004A);
        expect_out(1'b1, 24'h00006F);
        expect_out(1'b1, 24'h000014);
        wait_idle("t3");
        compare_q("t3");

        // 4: back-pressure fills the FIFO, then drains in order
        out_ready = 1'b0;
        group_yuv(8'h00, 8'h80, 8'h00, 8'h40);
        group_yuv(8'h10, 8'h80, 8'h00, 8'hFF);
        step();
        chk("t4_full_in_ready", 32'(in_ready), 32'd0);
        chk("t4_full_valid", 32'(out_valid), 32'd1);
        chk("t4_head", 32'(out_data), 32'h808080);
        step();
        step();
        step();
        chk("t4_hold", 32'(out_data), 32'h808080);
        chk("t4_still_blocked", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        expect_out(1'b0, 24'h808080);
        expect_out(1'b0, 24'h404040);
        expect_out(1'b0, 24'h807CA0);
        expect_out(1'b0, 24'hFFFBFF);
        wait_idle("t4");
        compare_q("t4");

        // 5: op_mode changes mid-group are ignored
        send(24'h000010, 1'b0);
        send(24'h000080, 1'b1);
        send(24'h000000, 1'b1);
        send(24'h000080, 1'b1);
        send(24'hFF0000, 1'b1);
        send(24'h0000FF, 1'b0);
        group_yuv(8'h00, 8'h80, 8'h00, 8'h40);
        expect_out(1'b0, 24'h807CA0);
        expect_out(1'b0, 24'h807CA0);
        expect_out(1'b1, 24'h0000DB);
        expect_out(1'b1, 24'h00004A);
        expect_out(1'b1, 24'h00006F);
        expect_out(1'b1, 24'h000014);
        expect_out(1'b0, 24'h808080);
        expect_out(1'b0, 24'h404040);
        wait_idle("t5");
        compare_q("t5");

        // 6: asynchronous reset mid-group with data queued
        out_ready = 1'b0;
        group_yuv(8'h00, 8'h80, 8'h00, 8'h40);
        send(24'h000010, 1'b0);
        send(24'h000080, 1'b0);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_idle", 32'(idle), 32'd1);
        chk("t6_rst_data", 32'(out_data), 32'd0);
`ifdef CTE_GROUP_CNT_EN
        chk("t6_rst_grp_cnt", 32'(grp_cnt), 32'd0);
`endif
        got_q.delete();
        exp_q.delete();
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        group_yuv(8'h10, 8'h80, 8'h00, 8'hFF);
        expect_out(1'b0, 24'h807CA0);
        expect_out(1'b0, 24'hFFFBFF);
        wait_idle("t6");
        compare_q("t6");
`ifdef CTE_GROUP_CNT_EN
        chk("t6_grp_cnt", 32'(grp_cnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cte_stream.md
Name: cte_stream

Overview:
- Streaming, parametrised successor of the contest Color Transform Engine.
- Converts YUV 4:2:2 byte streams (U,Y0,V,Y1) to RGB pixels, and RGB pixels to YUV 4:2:2, selected per 4:2:2 group.
- Uses valid/ready handshakes on both sides, a registered compute stage, and an output FIFO that absorbs back-pressure.
- Sits between the pixel source and frame buffer in the colour pipeline.

Parameters:
- DW, 8, component width in bits; U/V are two's-complement DW-bit values.
- FRAC, 3, fraction bits kept in the YUV->RGB datapath before rounding.
- OFIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.

Ports:
- clk_p      in   1     clock, rising-edge
- reset_n    in   1     asynchronous active-low reset
- op_mode    in   1     0 = YUV->RGB, 1 = RGB->YUV; sampled on the first beat of a group only
- in_valid   in   1     input beat valid
- in_ready   out  1     block accepts the beat when in_valid && in_ready
- in_data    in   3*DW  YUV mode: component in [DW-1:0], upper bits ignored; RGB mode: {R,G,B}
- out_valid  out  1     output beat valid (FIFO non-empty)
- out_ready  in   1     downstream accepts
- out_data   out  3*DW  YUV->RGB: {R,G,B}; RGB->YUV: component in [DW-1:0], upper bits 0
- out_mode   out  1     op_mode of the group that produced the current out_data
- idle       out  1     high when no group is in progress and the FIFO is empty

Behaviour:
- Reset (reset_n low, async): FSM to S_IDLE; FIFO empty; out_valid=0; out_data=0; out_mode=0; in_ready=1; idle=1. Mid-group reset drops all partial data.
- FSM states:
  - YUV path: S_IDLE(U), S_Y0, S_V, S_CALC0, S_Y1, S_CALC1.
  - RGB path: S_IDLE(P0), S_EMIT_U, S_EMIT_Y0, S_EMIT_V, S_P1, S_EMIT_Y1.
- Group mode: the mode register loads op_mode at the accepted beat in S_IDLE. op_mode changes mid-group are ignored.
- YUV->RGB:
  - Accept U, Y0, V on consecutive handshakes.
  - S_CALC0 pushes RGB(Y0,U,V) to the FIFO.
  - Accept Y1; S_CALC1 pushes RGB(Y1,U,V); return to S_IDLE.
  - R = Y + 1.625V; G = Y - 0.25U - 0.75V; B = Y + 2U.
  - Evaluate exactly at DW+4 integer bits plus FRAC bits, signed.
  - Round half-up at FRAC, then saturate to [0, 2^DW-1].
- RGB->YUV:
  - Accept P0; push U, Y0, V on three consecutive cycles (S_EMIT_*).
  - Accept P1; push Y1; return to S_IDLE.
  - Y = (9533R + 20654G + 2582B) >> 15, rounded half-up, saturated to 2^DW-1.
  - U = (-4766R - 10327G + 15093B) >> 15, rounded half-up, saturated to a signed DW range.
  - V = (14299R - 12710G - 1589B) >> 15, rounded half-up, saturated to a signed DW range.
  - Products are 2*DW+16 bits.
- in_ready = (state accepts input) && !FIFO-cannot-take-next-push. It is 0 in all S_CALC*/S_EMIT* states.
- Any push state stalls (holds state, no push) while the FIFO is full.
- Latency: accept of the enabling beat (V, Y1, P0, P1) → first result out_valid = 2 cycles when the FIFO is empty and out_ready=1.
- FIFO:
  - Simultaneous push and pop when full is legal; the pop frees the slot that cycle.
  - Read/write pointers wrap modulo OFIFO_DEPTH.
  - out_data is held stable while out_valid && !out_ready.
- Throughput:
  - YUV mode: 4 input beats → 2 outputs in 6 cycles minimum.
  - RGB mode: 2 pixels → 4 outputs in 6 cycles minimum.

Optional Feature:
- CTE_GROUP_CNT_EN defined:
  - Adds output grp_cnt [15:0].
  - Increments by 1 when the last push of each group completes; wraps at 0xFFFF → 0.
  - Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package cte_pkg holds:
  - mode enum (MODE_YUV2RGB=0, MODE_RGB2YUV=1)
  - FSM state enum
  - coefficient localparams: 9533, 20654, 2582, 4766, 10327, 15093, 14299, 12710, 1589; 1.625/0.25/0.75/2 as FRAC-bit fixed point
  - a saturate/round function
- One sub-module, cte_ofifo: parametrised synchronous FIFO (width 3*DW+1, depth OFIFO_DEPTH), same clk_p/reset_n.

Test Plan:
1. YUV mode, U=0x00, Y0=0x80, V=0x00, Y1=0x40, out_ready=1 → out_data 0x808080 then 0x404040; out_valid 2 cycles after the V beat.
2. YUV mode, U=0x10, Y=0x80, V=0x00 → 0x807CA0. Then Y=0xFF, U=0x00, V=0x7F → 0xFFA0FF (R saturated, G rounded 159.75→160).
3. RGB mode, P0=P1=0xFFFFFF → out beats 0x00, 0xFF, 0x00, 0xFF in order; P0=0x000000 → U=Y=V=0x00.
4. Back-pressure: hold out_ready=0 through test 1 (OFIFO_DEPTH=4) → in_ready drops once the FIFO is full. Release → no loss or duplication, order preserved.
5. Mode switch: toggle op_mode mid-group → ignored until S_IDLE; the next group uses the new mode and out_mode follows.
6. Assert reset_n low after the Y0 beat → out_valid=0 and idle=1 immediately. A fresh group produces correct results; grp_cnt=0 when CTE_GROUP_CNT_EN is defined.
